// File: rtl/cdr_pkg.sv
// rtl/cdr_pkg.sv - shared types and divider constants for the CDR loop controller
// Contents:
//   cdr_state_t : loop state (IDLE=0, ACQ=1, LOCK=2)
//   NB_P_*      : sampling-period divider limits, shared with the divider
package cdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } cdr_state_t;

  localparam logic [5:0] NB_P_MIN  = 6'd23;
  localparam logic [5:0] NB_P_RST  = 6'd25;
  localparam logic [5:0] NB_P_MAX  = 6'd27;
  localparam logic [5:0] NB_P_STEP = 6'd2;

endpackage

// File: rtl/cdr_vote_acc.sv
// rtl/cdr_vote_acc.sv - signed saturating early/late vote accumulator
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_edge       : transition pulse; i_early qualifies it (1 = +1, 0 = -1)
//   i_clr        : window boundary; restarts the window, same-cycle vote goes to the new one
//   o_acc        : signed vote sum of the current window
//   o_any_edge   : at least one edge seen in the current window
module cdr_vote_acc #(
  parameter int P_ACC_W = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_edge,
  input  logic                      i_early,
  input  logic                      i_clr,
  output logic signed [P_ACC_W-1:0] o_acc,
  output logic                      o_any_edge
);

  localparam logic signed [P_ACC_W-1:0] ACC_MAX = {1'b0, {(P_ACC_W-1){1'b1}}};
  localparam logic signed [P_ACC_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [P_ACC_W-1:0] ACC_ONE = {{(P_ACC_W-1){1'b0}}, 1'b1};

  logic signed [P_ACC_W-1:0] acc_q, acc_d, base;
  logic                      any_edge_q, any_edge_d;

  always_comb begin
    // Clear wins; the vote arriving with the clear seeds the next window.
    base       = i_clr ? '0 : acc_q;
    acc_d      = base;
    any_edge_d = (i_clr ? 1'b0 : any_edge_q) | i_edge;
    if (i_edge && i_early && (base != ACC_MAX)) begin
      acc_d = base + ACC_ONE;
    end else if (i_edge && !i_early && (base != ACC_MIN)) begin
      acc_d = base - ACC_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q      <= '0;
      any_edge_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      any_edge_q <= any_edge_d;
    end
  end

  assign o_acc      = acc_q;
  assign o_any_edge = any_edge_q;

endmodule

// File: rtl/cdr_loop_ctrl.sv
// rtl/cdr_loop_ctrl.sv - CDR loop controller: window decisions, request/apply handshake, lock FSM
// Ports:
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_edge, i_early      : edge pulse and its early/late qualifier
//   i_win_tick           : end-of-window pulse
//   i_apply              : divider adjustment slot, consumes a pending request
//   i_nb_p               : divider's current period count
//   o_T, o_E             : correction request and direction (0 = -2, 1 = +2)
//   o_state, o_locked    : loop state and lock flag
//   o_ovr_cnt            : saturating count of decisions dropped while a request was pending
module cdr_loop_ctrl
  import cdr_pkg::*;
#(
  parameter int P_ACC_W      = 6,
  parameter int P_ACQ_THR    = 1,
  parameter int P_TRK_THR    = 4,
  parameter int P_LOCK_WIN   = 8,
  parameter int P_UNLOCK_WIN = 3,
  parameter int P_LOS_WIN    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_edge,
  input  logic       i_early,
  input  logic       i_win_tick,
  input  logic       i_apply,
  input  logic [5:0] i_nb_p,
  output logic       o_T,
  output logic       o_E,
  output logic [1:0] o_state,
  output logic       o_locked,
  output logic [7:0] o_ovr_cnt
);

  localparam logic [7:0] LOCK_WIN   = 8'(P_LOCK_WIN);
  localparam logic [7:0] UNLOCK_WIN = 8'(P_UNLOCK_WIN);
  localparam logic [7:0] LOS_WIN    = 8'(P_LOS_WIN);

  logic signed [P_ACC_W-1:0] acc, thr;
  logic                      any_edge;

  cdr_state_t state_q, state_d;
  logic       t_q, t_d, e_q, e_d, locked_q, locked_d;
  logic [7:0] ovr_q, ovr_d, quiet_q, quiet_d, corr_q, corr_d, los_q, los_d;
  logic       dec_dn, dec_up, correct, t_held;

  cdr_vote_acc #(.P_ACC_W(P_ACC_W)) u_vote_acc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_edge     (i_edge),
    .i_early    (i_early),
    .i_clr      (i_win_tick),
    .o_acc      (acc),
    .o_any_edge (any_edge)
  );

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    ovr_d   = ovr_q;
    quiet_d = quiet_q;
    corr_d  = corr_q;
    los_d   = los_q;

    thr = (state_q == ST_LOCK) ? P_ACC_W'(P_TRK_THR) : P_ACC_W'(P_ACQ_THR);
    // A correction that would push the divider past its range is a quiet window.
    dec_dn  = (acc >= thr)  && (i_nb_p != NB_P_MIN);
    dec_up  = (acc <= -thr) && (i_nb_p != NB_P_MAX);
    correct = i_win_tick && (state_q != ST_IDLE) && (dec_dn || dec_up);

    // An apply in this cycle retires the old request before a new decision lands.
    t_held = t_q && !i_apply;
    t_d    = t_held;
    if (correct) begin
      if (t_held) begin
        ovr_d = (ovr_q == 8'hFF) ? ovr_q : ovr_q + 8'd1;
      end else begin
        t_d = 1'b1;
        e_d = !dec_dn;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (i_edge) state_d = ST_ACQ;
      end
      ST_ACQ: begin
        if (i_win_tick) begin
          if (correct) begin
            quiet_d = '0;
          end else if (quiet_q + 8'd1 == LOCK_WIN) begin
            state_d = ST_LOCK;
            quiet_d = '0;
            corr_d  = '0;
          end else begin
            quiet_d = quiet_q + 8'd1;
          end
        end
      end
      ST_LOCK: begin
        if (i_win_tick) begin
          if (!correct) begin
            corr_d = '0;
          end else if (corr_q + 8'd1 == UNLOCK_WIN) begin
            state_d = ST_ACQ;
            corr_d  = '0;
            quiet_d = '0;
          end else begin
            corr_d = corr_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loss of signal overrides any other transition taken in the same window.
    if (i_win_tick && (state_q != ST_IDLE)) begin
      if (any_edge) begin
        los_d = '0;
      end else if (los_q + 8'd1 == LOS_WIN) begin
        state_d = ST_IDLE;
        t_d     = 1'b0;
        quiet_d = '0;
        corr_d  = '0;
        los_d   = '0;
      end else begin
        los_d = los_q + 8'd1;
      end
    end

    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      t_q      <= 1'b0;
      e_q      <= 1'b0;
      locked_q <= 1'b0;
      ovr_q    <= '0;
      quiet_q  <= '0;
      corr_q   <= '0;
      los_q    <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      e_q      <= e_d;
      locked_q <= locked_d;
      ovr_q    <= ovr_d;
      quiet_q  <= quiet_d;
      corr_q   <= corr_d;
      los_q    <= los_d;
    end
  end

  assign o_T       = t_q;
  assign o_E       = e_q;
  assign o_state   = state_q;
  assign o_locked  = locked_q;
  assign o_ovr_cnt = ovr_q;

endmodule
